// File: rtl/fifo_wr_arbiter.sv
// Packet-oriented round-robin arbiter that shares one async_fifo write port. 1-cycle arbitration bubble per grant, then beats pass through combinationally.
// Backpressure: fifo_full or a stalled owner holds the grant with no write. While rst_n is low, no write is issued and req_ready stays low.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 8,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          wr_clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [ID_W-1:0]               gnt_id,
    output logic                          busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic               found;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    cand;

    // Rotating search: the slot just after the last served requester goes first.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Beat path; rst_n gating stops a write on the very edge that resets a burst.
    always_comb begin
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        if (state_q == BURST) begin
            req_ready[gnt_id_q] = ~fifo_full & rst_n;
            fifo_wr_en          = req_valid[gnt_id_q] & ~fifo_full & rst_n;
            fifo_din            = req_data[gnt_id_q*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = BURST;
                    gnt_d      = NUM_REQ'(1) << winner;
                    gnt_id_d   = winner;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (fifo_wr_en) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (req_last[gnt_id_q] || beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        rr_ptr_d = gnt_id_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            rr_ptr_q   <= ID_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester queues and a 16-deep FIFO occupancy model
// are advanced once per clock from the single stimulus process.
module tb_fifo_wr_arbiter;

    logic        wr_clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        busy;

    fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(8)) dut (
        .wr_clk    (wr_clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wr_en(fifo_wr_en),
        .fifo_din  (fifo_din),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy)
    );

    always #5 wr_clk = ~wr_clk;

    logic [7:0] bd [4][24];
    logic       bl [4][24];
    int         hd [4];
    int         tl [4];

    logic [7:0] wlog_d  [64];
    logic [3:0] wlog_g  [64];
    logic [1:0] wlog_id [64];
    int         wlog_c  [64];
    int         wn;
    int         cyc;
    int         fcount;
    logic       rd_en;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        bd[r][tl[r]] = d;
        bl[r][tl[r]] = l;
        tl[r]++;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < 4; i++) begin
            if (hd[i] < tl[i]) begin
                req_valid[i]       = 1'b1;
                req_last[i]        = bl[i][hd[i]];
                req_data[i*8 +: 8] = bd[i][hd[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_last[i]        = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
            end
        end
    endtask

    // Called at the negedge: record what the coming edge commits, then advance one clock.
    task automatic tick();
        #1;
        if (fifo_wr_en === 1'b1 && wn < 64) begin
            wlog_d[wn]  = fifo_din;
            wlog_g[wn]  = gnt;
            wlog_id[wn] = gnt_id;
            wlog_c[wn]  = cyc;
            wn++;
        end
        for (int i = 0; i < 4; i++)
            if (req_ready[i] === 1'b1 && req_valid[i]) hd[i]++;
        if (fifo_wr_en === 1'b1) fcount++;
        if (rd_en && fcount > 0) fcount--;
        @(posedge wr_clk);
        #1;
        cyc++;
        fifo_full = (fcount >= 16);
        drive_reqs();
        @(negedge wr_clk);
    endtask

    task automatic run_until(input int n, input string tag);
        int b = 0;
        while (wn < n && b < 200) begin
            tick();
            b++;
        end
        check({tag, "_count"}, wn, n);
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        rd_en     = 1'b0;
        fcount    = 0;
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        drive_reqs();
        tick();
        tick();
        wn    = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        wn = 0; cyc = 0; fcount = 0; rd_en = 1'b0; fifo_full = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        // Reset with every requester valid, then round-robin over 1-beat packets
        push(0, 8'h10, 1'b1);
        push(1, 8'h20, 1'b1);
        push(2, 8'h30, 1'b1);
        push(3, 8'h40, 1'b1);
        drive_reqs();
        @(posedge wr_clk);
        @(negedge wr_clk);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        tick();
        check("rst2_wr_en", fifo_wr_en, 0);
        check("rst2_gnt", gnt, 0);
        rst_n = 1'b1;
        tick();
        check("first_gnt", gnt, 4'b0001);
        check("first_gnt_id", gnt_id, 0);
        check("first_busy", busy, 1);
        check("first_din", fifo_din, 8'h10);
        check("first_ready", req_ready, 4'b0001);
        run_until(4, "rr");
        check("rr_d0", wlog_d[0], 8'h10);
        check("rr_d1", wlog_d[1], 8'h20);
        check("rr_d2", wlog_d[2], 8'h30);
        check("rr_d3", wlog_d[3], 8'h40);
        check("rr_g0", wlog_g[0], 4'b0001);
        check("rr_g1", wlog_g[1], 4'b0010);
        check("rr_g2", wlog_g[2], 4'b0100);
        check("rr_g3", wlog_g[3], 4'b1000);
        check("rr_gap01", wlog_c[1] - wlog_c[0], 2);
        check("rr_gap12", wlog_c[2] - wlog_c[1], 2);
        check("rr_gap23", wlog_c[3] - wlog_c[2], 2);
        tick();
        tick();
        check("rr_idle_busy", busy, 0);

        // Packet hold: req1 keeps the port for its 3-beat packet
        reset_dut();
        push(1, 8'hA1, 1'b0);
        push(1, 8'hA2, 1'b0);
        push(1, 8'hA3, 1'b1);
        push(2, 8'hB1, 1'b1);
        drive_reqs();
        run_until(4, "hold");
        check("hold_d0", wlog_d[0], 8'hA1);
        check("hold_d1", wlog_d[1], 8'hA2);
        check("hold_d2", wlog_d[2], 8'hA3);
        check("hold_d3", wlog_d[3], 8'hB1);
        check("hold_id2", wlog_id[2], 1);
        check("hold_id3", wlog_id[3], 2);
        check("hold_back2back", wlog_c[2] - wlog_c[0], 2);

        // Burst cap: 12 beats without last, split 8 + 4 around req3
        reset_dut();
        for (int k = 1; k <= 12; k++) push(0, 8'(k), 1'b0);
        push(3, 8'h33, 1'b1);
        drive_reqs();
        run_until(13, "cap");
        check("cap_d7", wlog_d[7], 8'h08);
        check("cap_id7", wlog_id[7], 0);
        check("cap_d8", wlog_d[8], 8'h33);
        check("cap_id8", wlog_id[8], 3);
        check("cap_d9", wlog_d[9], 8'h09);
        check("cap_d12", wlog_d[12], 8'h0C);
        check("cap_id12", wlog_id[12], 0);
        tick();
        tick();
        check("cap_stall_busy", busy, 1);
        check("cap_stall_gnt", gnt, 4'b0001);
        check("cap_stall_wr_en", fifo_wr_en, 0);

        // Full backpressure: 16 beats fill the FIFO, one read lets exactly one more in
        reset_dut();
        for (int k = 0; k < 20; k++) push(2, 8'(8'h40 + k), (k == 19));
        drive_reqs();
        run_until(16, "full");
        tick();
        tick();
        tick();
        check("full_no_write", wn, 16);
        check("full_wr_en", fifo_wr_en, 0);
        check("full_ready", req_ready, 0);
        check("full_busy", busy, 1);
        check("full_gnt", gnt, 4'b0100);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("drain_wr_en", fifo_wr_en, 1);
        check("drain_din", fifo_din, 8'h50);
        tick();
        tick();
        tick();
        check("drain_count", wn, 17);
        check("drain_d15", wlog_d[15], 8'h4F);
        check("drain_d16", wlog_d[16], 8'h50);
        check("drain_wr_en_after", fifo_wr_en, 0);

        // Mid-burst reset during req1's packet, after req0 was served
        reset_dut();
        push(0, 8'hE0, 1'b1);
        for (int k = 1; k <= 5; k++) push(1, 8'(8'hC0 + k), (k == 5));
        drive_reqs();
        run_until(3, "mrst_pre");
        check("mrst_pre_d2", wlog_d[2], 8'hC2);
        rst_n = 1'b0;
        #1;
        check("mrst_wr_en", fifo_wr_en, 0);
        check("mrst_ready", req_ready, 0);
        tick();
        check("mrst_busy", busy, 0);
        check("mrst_gnt", gnt, 0);
        push(0, 8'hF0, 1'b1);
        drive_reqs();
        tick();
        check("mrst_no_write", wn, 3);
        rst_n = 1'b1;
        tick();
        check("mrst_regnt", gnt, 4'b0001);
        check("mrst_regnt_id", gnt_id, 0);
        run_until(7, "mrst_post");
        check("mrst_d3", wlog_d[3], 8'hF0);
        check("mrst_d4", wlog_d[4], 8'hC3);
        check("mrst_d6", wlog_d[6], 8'hC5);
        check("mrst_id6", wlog_id[6], 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
